uart_rx_frame_ctrl: RTL and testbench

//  Sequences the byte stream from uart_rx into framed packets: hunts for a sync byte,

---
 rtl/uart_rx_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : Frames uart_rx bytes (A5, LEN, payload, CHK) into checked packets
//            held in an internal buffer and offered downstream via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int BAUD    = 9600,
   parameter int MAX_LEN = 16,
   parameter int TO_BITS = 30
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       pkt_valid,
   input  logic                       pkt_ready,
   output logic [$clog2(MAX_LEN):0]   pkt_len,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
   output logic [7:0]                 rd_data,
   output logic                       err_chk,
   output logic                       err_len,
   output logic                       err_to,
   output logic                       err_ovr,
   output logic [7:0]                 pkt_count
);
   localparam int AW         = $clog2(MAX_LEN);
   localparam int LW         = AW + 1;
   localparam int BIT_CYCLES = CLK_HZ / BAUD;
   localparam int TO_CYCLES  = TO_BITS * BIT_CYCLES;
   localparam int TW         = $clog2(TO_CYCLES + 1);
   localparam logic [7:0]    SYNC    = 8'hA5;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHK     = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [LW-1:0]   idx;
   logic [7:0]      chk_acc;
   logic [TW-1:0]   to_cnt;
   logic [7:0]      mem [MAX_LEN];

   logic latch_len, wr_en, pkt_set, pkt_clr, to_inc;
   logic err_chk_nxt, err_len_nxt, err_to_nxt, err_ovr_nxt;
   logic len_ok, last_byte;

   assign len_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= 9'(MAX_LEN));
   assign last_byte = ((idx + LW'(1)) == pkt_len);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      latch_len   = 1'b0;
      wr_en       = 1'b0;
      pkt_set     = 1'b0;
      pkt_clr     = 1'b0;
      to_inc      = 1'b0;
      err_chk_nxt = 1'b0;
      err_len_nxt = 1'b0;
      err_to_nxt  = 1'b0;
      err_ovr_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid && in_data == SYNC) state_nxt = S_LEN;
         end
         S_LEN, S_PAYLOAD, S_CHK: begin
            if (in_valid) begin
               if (state == S_LEN) begin
                  if (len_ok) begin
                     latch_len = 1'b1;
                     state_nxt = S_PAYLOAD;
                  end else begin
                     err_len_nxt = 1'b1;
                     state_nxt   = S_IDLE;
                  end
               end else if (state == S_PAYLOAD) begin
                  wr_en = 1'b1;
                  if (last_byte) state_nxt = S_CHK;
               end else if (in_data == chk_acc) begin
                  pkt_set   = 1'b1;
                  state_nxt = S_HOLD;
               end else begin
                  err_chk_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end
            end else if (to_cnt == TO_LAST) begin
               err_to_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end else begin
               to_inc = 1'b1;
            end
         end
         S_HOLD: begin
            // A release frees the parser in the same cycle, so a sync byte here starts a frame.
            if (pkt_ready) begin
               pkt_clr   = 1'b1;
               state_nxt = (in_valid && in_data == SYNC) ? S_LEN : S_IDLE;
            end else if (in_valid) begin
               err_ovr_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_len   <= '0;
         idx       <= '0;
         chk_acc   <= '0;
         to_cnt    <= '0;
         pkt_valid <= 1'b0;
         pkt_count <= '0;
         rd_data   <= '0;
         err_chk   <= 1'b0;
         err_len   <= 1'b0;
         err_to    <= 1'b0;
         err_ovr   <= 1'b0;
      end else begin
         err_chk <= err_chk_nxt;
         err_len <= err_len_nxt;
         err_to  <= err_to_nxt;
         err_ovr <= err_ovr_nxt;
         to_cnt  <= to_inc ? to_cnt + TW'(1) : '0;
         rd_data <= mem[rd_addr];
         if (latch_len) begin
            pkt_len <= LW'(in_data);
            chk_acc <= in_data;
            idx     <= '0;
         end
         if (wr_en) begin
            chk_acc <= chk_acc ^ in_data;
            idx     <= idx + LW'(1);
         end
         if (pkt_set) begin
            pkt_valid <= 1'b1;
            pkt_count <= pkt_count + 8'd1;
         end
         if (pkt_clr) pkt_valid <= 1'b0;
      end
   end

   // Buffer is never reset; only the PAYLOAD state writes it, so HOLD protects it.
   always_ff @(posedge clk) begin
      if (wr_en) mem[idx[AW-1:0]] <= in_data;
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Brief    : Directed bench for uart_rx_frame_ctrl with a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;
   localparam int MAX_LEN   = 16;
   localparam int CLK_HZ    = 1000;
   localparam int BAUD      = 100;
   localparam int TO_BITS   = 3;
   localparam int TO_CYCLES = TO_BITS * (CLK_HZ / BAUD);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       pkt_ready = 1'b0;
   logic [3:0] rd_addr = 4'd0;
   logic       pkt_valid, err_chk, err_len, err_to, err_ovr;
   logic [4:0] pkt_len;
   logic [7:0] rd_data, pkt_count;

   uart_rx_frame_ctrl #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_LEN(MAX_LEN), .TO_BITS(TO_BITS)
   ) dut (
      .clk(clk), .rst(rst_n), .in_data(in_data), .in_valid(in_valid),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
      .rd_addr(rd_addr), .rd_data(rd_data), .err_chk(err_chk), .err_len(err_len),
      .err_to(err_to), .err_ovr(err_ovr), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Frame model: bytes after the sync are kept in a queue and judged by position.
   logic [7:0] m_frm[$];
   logic [7:0] m_hbuf[MAX_LEN];
   bit         m_sync, m_held, rd_chk;
   int         m_quiet, m_hlen, e_len;
   bit         e_valid, e_chk, e_lenerr, e_to, e_ovr;
   logic [7:0] e_count, e_rd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_frm.delete();
         m_sync = 0; m_held = 0; rd_chk = 0; m_quiet = 0; m_hlen = 0; e_len = 0;
         e_valid = 0; e_chk = 0; e_lenerr = 0; e_to = 0; e_ovr = 0; e_count = 0; e_rd = 0;
      end else begin
         rd_chk = m_held && (int'(rd_addr) < m_hlen);
         if (rd_chk) e_rd = m_hbuf[rd_addr];
         e_chk = 0; e_lenerr = 0; e_to = 0; e_ovr = 0;
         if (m_held) begin
            if (pkt_ready) begin
               m_held = 0; e_valid = 0;
               if (in_valid && in_data == 8'hA5) begin
                  m_sync = 1; m_frm.delete(); m_quiet = 0;
               end
            end else if (in_valid) e_ovr = 1;
         end else if (!m_sync) begin
            if (in_valid && in_data == 8'hA5) begin
               m_sync = 1; m_frm.delete(); m_quiet = 0;
            end
         end else if (in_valid) begin
            int L;
            m_quiet = 0;
            m_frm.push_back(in_data);
            L = int'(m_frm[0]);
            if (m_frm.size() == 1) begin
               if (L == 0 || L > MAX_LEN) begin e_lenerr = 1; m_sync = 0; end
               else e_len = L;
            end else if (m_frm.size() == L + 2) begin
               logic [7:0] x;
               x = 0;
               for (int i = 0; i < L + 1; i++) x ^= m_frm[i];
               m_sync = 0;
               if (x == m_frm[L + 1]) begin
                  m_held = 1; e_valid = 1; e_count = e_count + 8'd1; m_hlen = L;
                  for (int i = 0; i < L; i++) m_hbuf[i] = m_frm[i + 1];
               end else e_chk = 1;
            end
         end else begin
            m_quiet++;
            if (m_quiet == TO_CYCLES) begin e_to = 1; m_sync = 0; end
         end
      end
   end

   always @(negedge clk) begin
      check("pkt_valid", int'(pkt_valid), int'(e_valid));
      check("pkt_len", int'(pkt_len), e_len);
      check("pkt_count", int'(pkt_count), int'(e_count));
      check("err_chk", int'(err_chk), int'(e_chk));
      check("err_len", int'(err_len), int'(e_lenerr));
      check("err_to", int'(err_to), int'(e_to));
      check("err_ovr", int'(err_ovr), int'(e_ovr));
      if (rst_n && rd_chk) check("rd_data", int'(rd_data), int'(e_rd));
      n_chk += int'(err_chk); n_len += int'(err_len);
      n_to  += int'(err_to);  n_ovr += int'(err_ovr);
   end

   task automatic strobe(input logic [7:0] b);
      @(posedge clk); #1; in_valid = 1'b1; in_data = b;
      @(posedge clk); #1; in_valid = 1'b0;
   endtask

   task automatic send_frame(input int len, input int first, input int step,
                             input logic [7:0] flip, input bit with_sync);
      logic [7:0] x, b;
      if (with_sync) strobe(8'hA5);
      x = 8'(len);
      strobe(8'(len));
      for (int i = 0; i < len; i++) begin
         b = 8'(first + i * step);
         x ^= b;
         strobe(b);
      end
      strobe(x ^ flip);
   endtask

   task automatic release_pkt();
      pkt_ready = 1'b1;
      @(posedge clk); #1; pkt_ready = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [3:0] a, input int exp);
      rd_addr = a;
      @(posedge clk); #1;
      check(name, int'(rd_data), exp);
   endtask

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pkt_valid", int'(pkt_valid), 0);
      check("reset_pkt_count", int'(pkt_count), 0);
      check("reset_pkt_len", int'(pkt_len), 0);
      check("reset_rd_data", int'(rd_data), 0);
      rst_n = 1'b1;

      // Good frame: valid the cycle after the CHK strobe
      strobe(8'hA5); strobe(8'h03); strobe(8'h11); strobe(8'h22); strobe(8'h33);
      check("t1_valid_before_chk", int'(pkt_valid), 0);
      strobe(8'h03);
      check("t1_valid", int'(pkt_valid), 1);
      check("t1_len", int'(pkt_len), 3);
      check("t1_count", int'(pkt_count), 1);
      read_chk("t1_rd0", 4'd0, 8'h11);
      read_chk("t1_rd1", 4'd1, 8'h22);
      read_chk("t1_rd2", 4'd2, 8'h33);
      release_pkt();
      check("t1_released", int'(pkt_valid), 0);

      // Checksum mismatch then recovery
      k = n_chk;
      strobe(8'hA5); strobe(8'h02); strobe(8'h10); strobe(8'h20); strobe(8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("t2_err_chk_once", n_chk - k, 1);
      check("t2_no_valid", int'(pkt_valid), 0);
      send_frame(2, 8'h10, 8'h10, 8'h00, 1'b1);
      check("t2_good_after", int'(pkt_valid), 1);
      check("t2_count", int'(pkt_count), 2);
      release_pkt();

      // Length boundaries
      k = n_len;
      strobe(8'hA5); strobe(8'h00);
      strobe(8'hA5); strobe(8'h11);
      @(posedge clk); #1;
      check("t3_err_len_twice", n_len - k, 2);
      check("t3_no_valid", int'(pkt_valid), 0);
      send_frame(16, 0, 1, 8'h00, 1'b1);
      check("t3_max_len_valid", int'(pkt_valid), 1);
      check("t3_max_len", int'(pkt_len), 16);
      read_chk("t3_rd15", 4'd15, 15);
      release_pkt();

      // Timeout fires once; a byte on the expiry cycle prevents it
      k = n_to;
      strobe(8'hA5); strobe(8'h04); strobe(8'h01);
      repeat (TO_CYCLES + 5) @(posedge clk);
      #1;
      check("t4_err_to_once", n_to - k, 1);
      k = n_to;
      strobe(8'hA5); strobe(8'h04); strobe(8'h01);
      repeat (TO_CYCLES - 2) @(posedge clk);
      strobe(8'h02); strobe(8'h03); strobe(8'h04); strobe(8'h00);
      check("t4_no_err_to", n_to - k, 0);
      check("t4_expiry_byte_frame", int'(pkt_valid), 1);
      release_pkt();

      // Overrun in HOLD, then release together with a sync strobe
      send_frame(1, 8'h7E, 0, 8'h00, 1'b1);
      k = n_ovr;
      strobe(8'h55); strobe(8'h66);
      @(posedge clk); #1;
      check("t5_err_ovr_twice", n_ovr - k, 2);
      check("t5_still_valid", int'(pkt_valid), 1);
      read_chk("t5_buf_kept", 4'd0, 8'h7E);
      k = n_ovr;
      @(posedge clk); #1; in_valid = 1'b1; in_data = 8'hA5; pkt_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; pkt_ready = 1'b0;
      check("t5_dropped", int'(pkt_valid), 0);
      send_frame(1, 8'h5A, 0, 8'h00, 1'b0);
      check("t5_next_valid", int'(pkt_valid), 1);
      check("t5_no_ovr", n_ovr - k, 0);
      read_chk("t5_next_rd", 4'd0, 8'h5A);
      release_pkt();

      // Async reset mid-payload, then count wrap
      strobe(8'hA5); strobe(8'h04); strobe(8'h01); strobe(8'h02);
      #2; rst_n = 1'b0;
      #1;
      check("t6_rst_count", int'(pkt_count), 0);
      check("t6_rst_len", int'(pkt_len), 0);
      check("t6_rst_valid", int'(pkt_valid), 0);
      check("t6_rst_rd", int'(rd_data), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      strobe(8'hA5); strobe(8'h03); strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h03);
      check("t6_after_rst_valid", int'(pkt_valid), 1);
      check("t6_after_rst_count", int'(pkt_count), 1);
      read_chk("t6_after_rst_rd1", 4'd1, 8'h22);
      pkt_ready = 1'b1;
      for (int i = 0; i < 254; i++) send_frame(1, 0, 0, 8'h00, 1'b1);
      check("t6_count_255", int'(pkt_count), 255);
      send_frame(1, 0, 0, 8'h00, 1'b1);
      check("t6_count_wrap", int'(pkt_count), 0);
      @(posedge clk); #1; pkt_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
